// File: rtl/exe_if.sv
// ---------------------------------------------------------------------------
// exe_if : ID/EXE -> EXE -> EXE/MEM signal bundle for the execute stage.
//
//   master (upstream / ID-EXE register side)
//     drives  : WB_En_ID, EXE_CMD_ID, dest_ID, val1_ID, val2_ID
//     samples : stall, WB_En_EXE, dest_EXE, ALU_result_EXE
//   slave  (exe_stage)
//     the mirror image of master
// ---------------------------------------------------------------------------
interface exe_if #(
    parameter int WIDTH = 32,
    parameter int CMD_W = 4
);
    logic             WB_En_ID;
    logic [CMD_W-1:0] EXE_CMD_ID;
    logic [4:0]       dest_ID;
    logic [WIDTH-1:0] val1_ID;
    logic [WIDTH-1:0] val2_ID;
    logic             stall;
    logic             WB_En_EXE;
    logic [4:0]       dest_EXE;
    logic [WIDTH-1:0] ALU_result_EXE;

    modport master (
        output WB_En_ID, EXE_CMD_ID, dest_ID, val1_ID, val2_ID,
        input  stall, WB_En_EXE, dest_EXE, ALU_result_EXE
    );

    modport slave (
        input  WB_En_ID, EXE_CMD_ID, dest_ID, val1_ID, val2_ID,
        output stall, WB_En_EXE, dest_EXE, ALU_result_EXE
    );
endinterface

// File: rtl/exe_stage.sv
// ---------------------------------------------------------------------------
// exe_stage : execute stage of the 5-stage pipeline.
//
// Single-cycle ALU operations are evaluated combinationally. MUL, DIVU and
// REMU run iteratively, one bit per cycle for WIDTH cycles, while stall holds
// the ID/EXE inputs steady. Outputs are combinational and are captured by the
// downstream EXE/MEM register.
//
// Ports
//   clk  in  clock, all state updates on posedge
//   rst  in  synchronous, active-high reset
//   bus  exe_if.slave
//          WB_En_ID / EXE_CMD_ID / dest_ID / val1_ID / val2_ID  (from ID/EXE)
//          stall                                              (to upstream)
//          WB_En_EXE / dest_EXE / ALU_result_EXE              (to EXE/MEM)
// ---------------------------------------------------------------------------
module exe_stage #(
    parameter int WIDTH = 32,
    parameter int CMD_W = 4
) (
    input  logic  clk,
    input  logic  rst,
    exe_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam int SH_W  = $clog2(WIDTH);

    localparam logic [CMD_W-1:0] C_ADD  = CMD_W'(0);
    localparam logic [CMD_W-1:0] C_SUB  = CMD_W'(1);
    localparam logic [CMD_W-1:0] C_AND  = CMD_W'(2);
    localparam logic [CMD_W-1:0] C_OR   = CMD_W'(3);
    localparam logic [CMD_W-1:0] C_NOR  = CMD_W'(4);
    localparam logic [CMD_W-1:0] C_XOR  = CMD_W'(5);
    localparam logic [CMD_W-1:0] C_SLL  = CMD_W'(6);
    localparam logic [CMD_W-1:0] C_SRL  = CMD_W'(7);
    localparam logic [CMD_W-1:0] C_SRA  = CMD_W'(8);
    localparam logic [CMD_W-1:0] C_MUL  = CMD_W'(9);
    localparam logic [CMD_W-1:0] C_DIVU = CMD_W'(10);
    localparam logic [CMD_W-1:0] C_REMU = CMD_W'(11);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CMD_W-1:0] r_cmd;
    // r_a   : multiplicand (MUL) / dividend shifting into quotient (DIV/REM)
    // r_b   : multiplier   (MUL) / divisor
    // r_acc : product      (MUL) / partial remainder
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;

    logic             w_is_md;
    logic             w_md_start;
    logic             w_last;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_rem_ge;
    logic [WIDTH-1:0] w_rem_diff;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_md_res;

    // Single-cycle ALU; codes outside 0-8 (including the MD codes) yield 0.
    function automatic logic [WIDTH-1:0] alu_f(
        input logic [CMD_W-1:0] cmd,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic signed [WIDTH-1:0] a_s;
        logic        [SH_W-1:0]  sh;
        a_s = signed'(a);
        sh  = b[SH_W-1:0];
        case (cmd)
            C_ADD:   alu_f = a + b;
            C_SUB:   alu_f = a - b;
            C_AND:   alu_f = a & b;
            C_OR:    alu_f = a | b;
            C_NOR:   alu_f = ~(a | b);
            C_XOR:   alu_f = a ^ b;
            C_SLL:   alu_f = a << sh;
            C_SRL:   alu_f = a >> sh;
            C_SRA:   alu_f = a_s >>> sh;
            default: alu_f = '0;
        endcase
    endfunction

    assign w_alu      = alu_f(bus.EXE_CMD_ID, bus.val1_ID, bus.val2_ID);
    assign w_is_md    = (bus.EXE_CMD_ID == C_MUL) || (bus.EXE_CMD_ID == C_DIVU) ||
                        (bus.EXE_CMD_ID == C_REMU);
    assign w_md_start = bus.WB_En_ID && w_is_md;
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

    // Restoring division step. The true difference always fits in WIDTH bits
    // whenever it is taken (partial remainder < divisor), so the low bits of
    // the subtraction are exact. A zero divisor always "fits", which gives
    // quotient all-ones and remainder = dividend.
    assign w_rem_sh   = {r_acc, r_a[WIDTH-1]};
    assign w_rem_ge   = (w_rem_sh >= {1'b0, r_b});
    assign w_rem_diff = w_rem_sh[WIDTH-1:0] - r_b;

    assign w_md_res   = (r_cmd == C_DIVU) ? r_a : r_acc;

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---- next state and EXE/MEM-facing outputs ----
    always_comb begin
        w_state_nxt        = r_state;
        bus.stall          = 1'b0;
        bus.WB_En_EXE      = 1'b0;
        bus.dest_EXE       = '0;
        bus.ALU_result_EXE = '0;
        case (r_state)
            S_IDLE: begin
                if (w_md_start) begin
                    w_state_nxt = S_RUN;
                    bus.stall   = 1'b1;
                end else begin
                    bus.WB_En_EXE      = bus.WB_En_ID;
                    bus.dest_EXE       = bus.dest_ID;
                    bus.ALU_result_EXE = w_alu;
                end
            end
            S_RUN: begin
                bus.stall = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt        = S_IDLE;
                bus.WB_En_EXE      = bus.WB_En_ID;
                bus.dest_EXE       = bus.dest_ID;
                bus.ALU_result_EXE = w_md_res;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Reset masks everything so a discarded MD op never writes back.
        if (rst) begin
            bus.stall          = 1'b0;
            bus.WB_En_EXE      = 1'b0;
            bus.dest_EXE       = '0;
            bus.ALU_result_EXE = '0;
        end
    end

    // ---- iterative MUL / DIV datapath ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_cmd <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_md_start) begin
                        r_cnt <= '0;
                        r_cmd <= bus.EXE_CMD_ID;
                        r_a   <= bus.val1_ID;
                        r_b   <= bus.val2_ID;
                        r_acc <= '0;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cmd == C_MUL) begin
                        // shift-add: low WIDTH bits of the product only
                        r_acc <= r_acc + (r_b[0] ? r_a : '0);
                        r_a   <= r_a << 1;
                        r_b   <= r_b >> 1;
                    end else begin
                        r_acc <= w_rem_ge ? w_rem_diff : w_rem_sh[WIDTH-1:0];
                        r_a   <= {r_a[WIDTH-2:0], w_rem_ge};
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_exe_stage.sv
// ---------------------------------------------------------------------------
// tb_exe_stage : self-checking bench for exe_stage.
// A cycle-level reference model (plain arithmetic for the MD results, a
// stall-cycle countdown for timing) is compared against the DUT on every
// negedge; directed tests add literal expectations.
// ---------------------------------------------------------------------------
module tb_exe_stage;
    localparam int WIDTH = 32;
    localparam int CMD_W = 4;

    logic clk = 1'b0;
    logic rst;

    exe_if #(.WIDTH(WIDTH), .CMD_W(CMD_W)) bus ();

    exe_stage #(.WIDTH(WIDTH), .CMD_W(CMD_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_alu(input int cmd, input logic [31:0] a,
                                            input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (cmd)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return ~(a | b);
            5: return a ^ b;
            6: return a << sh;
            7: return a >> sh;
            8: return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_md(input int cmd, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] p;
        p = {32'h0, a} * {32'h0, b};
        case (cmd)
            9:  return p[31:0];
            10: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    int          m_left = 0;   // stall cycles still owed by the running MD op
    bit          m_done = 0;   // result cycle pending
    logic [31:0] m_res  = '0;
    logic        e_stall, e_wb;
    logic [31:0] e_res;
    logic [4:0]  e_dest;
    bit          e_dest_chk;
    bit          m_start;
    int          m_cmd;

    always @(negedge clk) begin
        m_cmd   = int'(bus.EXE_CMD_ID);
        m_start = bus.WB_En_ID && (m_cmd >= 9) && (m_cmd <= 11);
        e_stall = 1'b0; e_wb = 1'b0; e_res = '0; e_dest = '0; e_dest_chk = 1'b1;
        if (rst) begin
            // all zero
        end else if (m_done) begin
            e_wb = bus.WB_En_ID; e_dest = bus.dest_ID; e_res = m_res;
        end else if (m_left > 0 || m_start) begin
            e_stall = 1'b1; e_dest_chk = 1'b0;
        end else begin
            e_wb = bus.WB_En_ID; e_dest = bus.dest_ID;
            e_res = ref_alu(m_cmd, bus.val1_ID, bus.val2_ID);
        end
        chk("mdl_stall", bus.stall, e_stall);
        chk("mdl_wb", bus.WB_En_EXE, e_wb);
        chk("mdl_res", bus.ALU_result_EXE, e_res);
        if (e_dest_chk) chk("mdl_dest", bus.dest_EXE, e_dest);
        // advance model to the next cycle
        if (rst) begin
            m_left = 0; m_done = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_done = 1;
        end else if (m_start) begin
            m_left = WIDTH;
            m_res  = ref_md(m_cmd, bus.val1_ID, bus.val2_ID);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic wb, input int cmd, input logic [4:0] dest,
                         input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        bus.WB_En_ID   = wb;
        bus.EXE_CMD_ID = CMD_W'(cmd);
        bus.dest_ID    = dest;
        bus.val1_ID    = a;
        bus.val2_ID    = b;
    endtask

    task automatic alu_chk(input string name, input int cmd, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] dest,
                           input logic [31:0] exp);
        drive(1'b1, cmd, dest, a, b);
        @(negedge clk);
        chk({name, "_res"}, bus.ALU_result_EXE, exp);
        chk({name, "_stall"}, bus.stall, 1'b0);
        chk({name, "_wb"}, bus.WB_En_EXE, 1'b1);
        chk({name, "_dest"}, bus.dest_EXE, dest);
    endtask

    // Issues an MD op, holds inputs while stalled, checks the single result cycle.
    task automatic md_op(input string name, input int cmd, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] dest,
                         input logic [31:0] exp, output int t_wb);
        int n;
        drive(1'b1, cmd, dest, a, b);
        n = 0;
        @(negedge clk);
        while (bus.stall === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({name, "_stallcnt"}, n, WIDTH + 1);
        chk({name, "_res"}, bus.ALU_result_EXE, exp);
        chk({name, "_wb"}, bus.WB_En_EXE, 1'b1);
        chk({name, "_dest"}, bus.dest_EXE, dest);
        t_wb = cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2;
        rst            = 1'b1;
        bus.WB_En_ID   = 1'b1;
        bus.EXE_CMD_ID = '0;
        bus.dest_ID    = 5'd5;
        bus.val1_ID    = 32'd1;
        bus.val2_ID    = 32'd2;

        // reset: outputs forced to zero even with a live ADD on the inputs
        @(negedge clk);
        chk("rst_stall", bus.stall, 1'b0);
        chk("rst_wb", bus.WB_En_EXE, 1'b0);
        chk("rst_dest", bus.dest_EXE, 5'd0);
        chk("rst_res", bus.ALU_result_EXE, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // T1 single-cycle ALU
        alu_chk("t1_add", 0, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'd4);
        alu_chk("t1_sub", 1, 32'd0, 32'd1, 5'd2, 32'hFFFF_FFFF);
        alu_chk("t1_nor", 4, 32'd0, 32'd0, 5'd3, 32'hFFFF_FFFF);
        alu_chk("t1_sra", 8, 32'h8000_0000, 32'd4, 5'd4, 32'hF800_0000);
        alu_chk("t1_sll", 6, 32'h0000_0001, 32'd31, 5'd5, 32'h8000_0000);
        alu_chk("t1_srl", 7, 32'h8000_0000, 32'h24, 5'd6, 32'h0800_0000);
        alu_chk("t1_xor", 5, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd7, 32'h0FF0_0FF0);

        // T2 MUL, then a bubble proves the writeback lasted one cycle
        md_op("t2_mul", 9, 32'h0001_0000, 32'h0001_0001, 5'd9, 32'h0001_0000, t1);
        drive(1'b0, 0, 5'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk("t2_single_wb", bus.WB_En_EXE, 1'b0);

        // T3 DIVU / REMU including divide by zero
        md_op("t3_divu", 10, 32'd100, 32'd7, 5'd10, 32'd14, t1);
        md_op("t3_remu", 11, 32'd100, 32'd7, 5'd11, 32'd2, t1);
        md_op("t3_div0", 10, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF, t1);
        md_op("t3_rem0", 11, 32'd5, 32'd0, 5'd13, 32'd5, t1);

        // T4 back-to-back MUL then DIVU
        md_op("t4_mul", 9, 32'd3, 32'd5, 5'd14, 32'd15, t1);
        md_op("t4_divu", 10, 32'd1000, 32'd10, 5'd15, 32'd100, t2);
        chk("t4_gap", t2 - t1, 34);
        drive(1'b0, 0, 5'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk("t4_no_dup", bus.WB_En_EXE, 1'b0);

        // T5 reset while RUN counter is 10
        drive(1'b1, 9, 5'd16, 32'd3, 32'd4);
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t5_stall", bus.stall, 1'b0);
        chk("t5_wb", bus.WB_En_EXE, 1'b0);
        @(posedge clk);
        #1;
        rst            = 1'b0;
        bus.WB_En_ID   = 1'b1;
        bus.EXE_CMD_ID = '0;
        bus.dest_ID    = 5'd17;
        bus.val1_ID    = 32'd2;
        bus.val2_ID    = 32'd2;
        @(negedge clk);
        chk("t5_add_res", bus.ALU_result_EXE, 32'd4);
        chk("t5_add_stall", bus.stall, 1'b0);
        chk("t5_add_wb", bus.WB_En_EXE, 1'b1);

        // T6 MUL code without writeback, and an unused code
        drive(1'b0, 9, 5'd18, 32'd5, 32'd6);
        @(negedge clk);
        chk("t6_bub_stall", bus.stall, 1'b0);
        chk("t6_bub_wb", bus.WB_En_EXE, 1'b0);
        drive(1'b1, 13, 5'd19, 32'hDEAD_BEEF, 32'h1234_5678);
        @(negedge clk);
        chk("t6_c13_res", bus.ALU_result_EXE, 32'h0);
        chk("t6_c13_stall", bus.stall, 1'b0);
        chk("t6_c13_wb", bus.WB_En_EXE, 1'b1);

        drive(1'b0, 0, 5'd0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
